// File: rtl/pool_stream_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : pool_stream_unit_if
//  Description : Stream/control bundle for pool_stream_unit. The master side
//                feeds samples and accepts results. The slave side is the
//                pooling engine.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pool_stream_unit_if #(
    parameter int DATA_W = 32
);
    logic              clear;
    logic              mode;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              busy;

    modport master (
        output clear, mode, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  clear, mode, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface
`default_nettype wire

// File: rtl/pool_stream_unit.sv
`default_nettype none
// ============================================================================
//  Module      : pool_stream_unit
//  Description : Streaming pooling engine. It reduces every WIN accepted
//                samples to one MAX or AVERAGE result. Mode is chosen per
//                window. The input and output use valid/ready handshakes.
//  Revision    : 1.0 - initial release
// ============================================================================
module pool_stream_unit #(
    parameter int DATA_W = 32,
    parameter int WIN    = 4,       // power of two, 2..64
    parameter bit SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    pool_stream_unit_if.slave bus
);

    localparam int c_log_win = $clog2(WIN);
    localparam int c_acc_w   = DATA_W + c_log_win;
    localparam int c_cnt_w   = c_log_win;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIN - 1);

    logic [c_cnt_w-1:0] r_cnt;
    logic [c_acc_w-1:0] r_acc;
    logic               r_mode;
    logic               r_out_valid;
    logic [DATA_W-1:0]  r_out_data;

    logic               w_in_ready;
    logic               w_accept;
    logic               w_out_fire;
    logic               w_first;
    logic               w_mode;
    logic               w_gt;
    logic [c_acc_w-1:0] w_ext;
    logic [c_acc_w-1:0] w_acc_next;
    logic [DATA_W-1:0]  w_result;

    // Input stalls only while a finished result is waiting on the consumer.
    assign w_in_ready = !r_out_valid || bus.out_ready;
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_out_fire = r_out_valid && bus.out_ready;

    // The first sample of a window picks the mode. Later samples use the latched copy.
    assign w_first = (r_cnt == '0);
    assign w_mode  = w_first ? bus.mode : r_mode;

    // Widen the sample to accumulator width. It is sign-extended only in signed mode.
    assign w_ext = {{c_log_win{SIGNED & bus.in_data[DATA_W-1]}}, bus.in_data};

    // A strict greater-than keeps the held value on a tie.
    assign w_gt = SIGNED ? ($signed(bus.in_data) > $signed(r_acc[DATA_W-1:0]))
                         : (bus.in_data > r_acc[DATA_W-1:0]);

    // Accumulator value after folding in the offered sample.
    always_comb begin
        w_acc_next = r_acc;
        if (w_first) begin
            w_acc_next = w_ext;
        end else if (w_mode) begin
            w_acc_next = r_acc + w_ext;
        end else if (w_gt) begin
            w_acc_next = w_ext;
        end
    end

    // Dividing by WIN is a right shift by log2(WIN). The low DATA_W bits of the
    // shifted sum are the same for arithmetic and logical shifts. A plain slice
    // therefore gives the truncated average in both signedness modes.
    assign w_result = w_mode ? w_acc_next[c_acc_w-1:c_log_win]
                             : w_acc_next[DATA_W-1:0];

    // Window counter, accumulator, mode latch and registered result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_acc       <= '0;
            r_mode      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            if (w_out_fire) begin
                r_out_valid <= 1'b0;
            end
            if (bus.clear) begin
                r_cnt <= '0;
                r_acc <= '0;
            end else if (w_accept) begin
                if (w_first) begin
                    r_mode <= bus.mode;
                end
                if (r_cnt == c_last) begin
                    r_out_data  <= w_result;
                    r_out_valid <= 1'b1;
                    r_cnt       <= '0;
                    r_acc       <= '0;
                end else begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + c_cnt_w'(1);
                end
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.busy      = (r_cnt != '0);

endmodule
`default_nettype wire

// File: tb/tb_pool_stream_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pool_stream_unit
//  Description : Self-checking bench. One unsigned and one signed instance
//                receive the same stimulus. A scoreboard queues the expected
//                result of each completed window.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pool_stream_unit;

    localparam int DW = 32;
    localparam int WN = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear = 1'b0;
    logic          mode = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b1;
    logic [DW-1:0] in_data = '0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pool_stream_unit_if #(.DATA_W(DW)) bus_u ();
    pool_stream_unit_if #(.DATA_W(DW)) bus_s ();

    assign bus_u.clear     = clear;
    assign bus_u.mode      = mode;
    assign bus_u.in_valid  = in_valid;
    assign bus_u.in_data   = in_data;
    assign bus_u.out_ready = out_ready;
    assign bus_s.clear     = clear;
    assign bus_s.mode      = mode;
    assign bus_s.in_valid  = in_valid;
    assign bus_s.in_data   = in_data;
    assign bus_s.out_ready = out_ready;

    pool_stream_unit #(.DATA_W(DW), .WIN(WN), .SIGNED(1'b0)) dut_u (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_u.slave)
    );

    pool_stream_unit #(.DATA_W(DW), .WIN(WN), .SIGNED(1'b1)) dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_s.slave)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference result for one complete window.
    function automatic logic [DW-1:0] model(input bit sgn, input bit m, input logic [DW-1:0] s[$]);
        logic [DW-1:0] r;
        longint        sum;
        longint        q;
        if (!m) begin
            r = s[0];
            foreach (s[i]) begin
                if (sgn ? ($signed(s[i]) > $signed(r)) : (s[i] > r)) r = s[i];
            end
            return r;
        end
        sum = 0;
        foreach (s[i]) sum += sgn ? longint'($signed(s[i])) : longint'(s[i]);
        q = sum / WN;
        if ((sum % WN != 0) && (sum < 0)) q = q - 1;
        return q[DW-1:0];
    endfunction

    logic [DW-1:0] win_q[$];
    logic          win_mode;
    logic [DW-1:0] exp_u[$];
    logic [DW-1:0] exp_s[$];

    // Scoreboard. Inputs change just after a rising edge, so at the falling
    // edge they already show what the next rising edge will do.
    always @(negedge clk) begin
        if (!rst_n) begin
            win_q.delete();
            exp_u.delete();
            exp_s.delete();
        end else begin
            if (bus_u.out_valid && out_ready) begin
                chk("u_sb_has_entry", 32'(exp_u.size() != 0), 32'd1);
                if (exp_u.size() != 0) chk("u_result", bus_u.out_data, exp_u.pop_front());
            end
            if (bus_s.out_valid && out_ready) begin
                chk("s_sb_has_entry", 32'(exp_s.size() != 0), 32'd1);
                if (exp_s.size() != 0) chk("s_result", bus_s.out_data, exp_s.pop_front());
            end
            if (clear) begin
                win_q.delete();
            end else if (in_valid && bus_u.in_ready) begin
                if (win_q.size() == 0) win_mode = mode;
                win_q.push_back(in_data);
                if (win_q.size() == WN) begin
                    exp_u.push_back(model(1'b0, win_mode, win_q));
                    exp_s.push_back(model(1'b1, win_mode, win_q));
                    win_q.delete();
                end
            end
        end
    end

    // Offers one sample and returns once the next rising edge accepts it.
    task automatic send(input logic [DW-1:0] d, output int cyc);
        bit acc;
        acc = 1'b0;
        cyc = 0;
        in_valid = 1'b1;
        in_data  = d;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            acc = bus_u.in_ready;
            @(posedge clk);
            #1;
            cyc++;
            if (acc) break;
        end
        if (!acc) chk("send_timeout", 32'(acc), 32'd1);
    endtask

    // Sends samples back to back and checks that no sample stalled.
    task automatic burst(input string tag, input logic [DW-1:0] d[$]);
        int c;
        int total;
        total = 0;
        foreach (d[i]) begin
            send(d[i], c);
            total += c;
        end
        in_valid = 1'b0;
        chk(tag, 32'(total), 32'(d.size()));
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        chk("rst_u_out_valid", 32'(bus_u.out_valid), 0);
        chk("rst_u_out_data", bus_u.out_data, 0);
        chk("rst_u_busy", 32'(bus_u.busy), 0);
        chk("rst_s_out_valid", 32'(bus_s.out_valid), 0);
        chk("rst_in_ready", 32'(bus_u.in_ready), 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1);

        // T1: max of 3,9,2,7. Result appears on the 4th accept edge for one cycle.
        mode = 1'b0;
        burst("t1_cycles", '{32'd3, 32'd9, 32'd2, 32'd7});
        chk("t1_out_valid", 32'(bus_u.out_valid), 1);
        chk("t1_u_data", bus_u.out_data, 32'd9);
        chk("t1_s_data", bus_s.out_data, 32'd9);
        idle(1);
        chk("t1_pulse_end", 32'(bus_u.out_valid), 0);

        // T2: two averaging windows back to back, no bubble.
        mode = 1'b1;
        burst("t2_no_bubble", '{32'd4, 32'd8, 32'd12, 32'd16, 32'd1, 32'd2, 32'd2, 32'd2});
        chk("t2_second_avg", bus_u.out_data, 32'd1);
        idle(2);

        // A mode change inside a window is ignored.
        mode = 1'b0;
        burst("mode_mid_first", '{32'd5});
        mode = 1'b1;
        burst("mode_mid_rest", '{32'd1, 32'd1, 32'd1});
        chk("mode_mid_max", bus_u.out_data, 32'd5);
        idle(2);

        // T3: negative samples. The signed instance must give -1 and -2.
        mode = 1'b0;
        burst("t3_max_cycles", '{-32'sd5, -32'sd3, -32'sd8, -32'sd1});
        chk("t3_s_max", bus_s.out_data, 32'hFFFF_FFFF);
        mode = 1'b1;
        burst("t3_avg_cycles", '{-32'sd1, -32'sd2, -32'sd2, -32'sd2});
        chk("t3_s_avg", bus_s.out_data, 32'hFFFF_FFFE);
        idle(2);

        // T4: backpressure holds the result and stalls the input.
        mode = 1'b0;
        out_ready = 1'b0;
        burst("t4_cycles", '{32'd3, 32'd9, 32'd2, 32'd7});
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t4_in_ready_low", 32'(bus_u.in_ready), 0);
            chk("t4_hold_valid", 32'(bus_u.out_valid), 1);
            chk("t4_hold_data", bus_u.out_data, 32'd9);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("t4_in_ready_high", 32'(bus_u.in_ready), 1);
        @(posedge clk); #1;
        chk("t4_drained", 32'(bus_u.out_valid), 0);
        idle(1);

        // T5: clear after two samples drops the window and the offered sample.
        mode = 1'b0;
        burst("t5_pre_cycles", '{32'd50, 32'd60});
        chk("t5_busy_before", 32'(bus_u.busy), 1);
        clear = 1'b1; in_valid = 1'b1; in_data = 32'd77;
        @(posedge clk); #1;
        clear = 1'b0; in_valid = 1'b0;
        chk("t5_busy_after_clear", 32'(bus_u.busy), 0);
        chk("t5_s_busy_after_clear", 32'(bus_s.busy), 0);
        burst("t5_post_cycles", '{32'd1, 32'd1, 32'd1, 32'd5});
        chk("t5_result", bus_u.out_data, 32'd5);
        idle(2);

        // When clear arrives on the last accept edge, clear wins and no result is produced.
        burst("clr_last_cycles", '{32'd1, 32'd2, 32'd3});
        clear = 1'b1; in_valid = 1'b1; in_data = 32'd99;
        @(posedge clk); #1;
        clear = 1'b0; in_valid = 1'b0;
        chk("clr_last_no_valid", 32'(bus_u.out_valid), 0);
        chk("clr_last_busy", 32'(bus_u.busy), 0);
        idle(2);

        // T6a: reset in the middle of a window.
        burst("t6_partial_cycles", '{32'd5, 32'd6, 32'd7});
        rst_n = 1'b0;
        #1;
        chk("t6a_busy", 32'(bus_u.busy), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // T6b: reset while a result is pending and blocked.
        out_ready = 1'b0;
        burst("t6_pend_cycles", '{32'd3, 32'd9, 32'd2, 32'd7});
        chk("t6b_pending", 32'(bus_u.out_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("t6b_out_valid", 32'(bus_u.out_valid), 0);
        chk("t6b_out_data", bus_u.out_data, 0);
        chk("t6b_s_out_data", bus_s.out_data, 0);
        chk("t6b_busy", 32'(bus_u.busy), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        mode = 1'b1;
        burst("t6_fresh_cycles", '{32'd20, 32'd40, 32'd60, 32'd80});
        chk("t6_fresh_avg", bus_u.out_data, 32'd50);
        idle(3);

        chk("sb_drained", 32'(exp_u.size() + exp_s.size()), 0);
        chk("win_empty", 32'(win_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
